vme_mem_master: RTL
===================

VME_MEM_MASTER -- requirements
Module: vme_mem_master

Interface
REQ-001 Parameter ADDR_WIDTH, 2, word-address MSB+1; bus address is bits [ADDR_WIDTH-1:1].
REQ-002 Parameter TIMEOUT, 15, max WAIT cycles before abort; legal range 1..255.
REQ-003 Clk  in  1  single clock; all logic rising-edge.
REQ-004 Rst  in  1  reset, asynchronous, active-high.
REQ-005 host_req  in  1  one-cycle request pulse; accepted only when host_busy=0.
REQ-006 host_we  in  1  1=write, 0=read; sampled with host_req.
REQ-007 host_addr  in  ADDR_WIDTH-1  word address; sampled with host_req.
REQ-008 host_wdata  in  16  write data; sampled with host_req.
REQ-009 host_busy  out  1  transaction in flight.
REQ-010 host_ack  out  1  one-cycle completion pulse.
REQ-011 host_err  out  1  valid with host_ack; 1=timeout abort.
REQ-012 host_rdata  out  16  read data; valid with host_ack on reads.
REQ-013 host_drop  out  1  one-cycle pulse: host_req arrived while busy, discarded.
REQ-014 VMEAddr  out  [ADDR_WIDTH-1:1]  slave address, held for whole transaction.
REQ-015 VMEWrData  out  16  slave write data, held for whole transaction.
REQ-016 VMERdMem  out  1  one-cycle read strobe.
REQ-017 VMEWrMem  out  1  one-cycle write strobe.
REQ-018 VMERdData  in  16  slave read data, valid with VMERdDone.
REQ-019 VMERdDone  in  1  slave read completion.
REQ-020 VMEWrDone  in  1  slave write completion.
REQ-021 timeout_count  out  8  saturating count of timed-out transactions.

Function
REQ-022 FSM states IDLE, STROBE, WAIT; all outputs registered.
REQ-023 IDLE: on host_req, latch we/addr/wdata into VMEAddr/VMEWrData, go STROBE, host_busy=1 next cycle.
REQ-024 STROBE: exactly one cycle of VMERdMem (read) or VMEWrMem (write), never both; then WAIT with wait counter=0.
REQ-025 WAIT: samples only the done matching the direction (VMERdDone for reads, VMEWrDone for writes); other done ignored.
REQ-026 Done in WAIT: next cycle host_ack=1, host_err=0, host_rdata=VMERdData (reads; writes leave host_rdata unchanged); return IDLE, host_busy=0.
REQ-027 No done: counter increments per WAIT cycle; when counter=TIMEOUT-1 without done, next cycle host_ack=1, host_err=1, host_rdata=16'hFFFF, timeout_count+1 (saturate at 255), return IDLE.
REQ-028 Done and timeout in same cycle: done wins, host_err=0, timeout_count unchanged.
REQ-029 Done seen in IDLE or STROBE: ignored, no ack.
REQ-030 host_req while host_busy=1 (incl. ack cycle): discarded, host_drop pulses next cycle, state unaffected.
REQ-031 Back-to-back: host_req in cycle after host_ack is accepted.
REQ-032 Latency with a one-register-stage slave: host_req edge N -> strobe cycle N+1 -> done cycle N+2 -> host_ack cycle N+3.

Reset
REQ-033 Rst asserted, any state: FSM=IDLE, strobes=0, host_busy/ack/err/drop=0, host_rdata=0, VMEAddr=0, VMEWrData=0, counter=0, timeout_count=0, immediately (asynchronous).
REQ-034 Transaction interrupted by reset is abandoned; no ack after release; first host_req after release accepted.

Structure
REQ-035 Shared package holds the FSM state enum, TIMEOUT_RDATA constant (16'hFFFF) and 16-bit data width constant.
REQ-036 Single module, no sub-modules; wait counter and timeout_count inline.

Verification
REQ-037 Write addr 1 data 16'h1234 to registered slave -> one VMEWrMem cycle, VMEAddr=1, host_ack at req+3, host_err=0.
REQ-038 Read addr 0, slave returns 16'hBEEF -> one VMERdMem cycle, host_ack at req+3, host_rdata=16'hBEEF.
REQ-039 Read with slave silent, TIMEOUT=15 -> host_ack at req+17, host_err=1, host_rdata=16'hFFFF, timeout_count=1.
REQ-040 Slave done on exact timeout cycle -> host_err=0; host_req during WAIT -> host_drop pulse, single ack only.
REQ-041 Rst pulsed during WAIT, then slave done -> no host_ack, all outputs 0; next read completes normally.

Source files
------------

// File: rtl/vme_mem_master_pkg.sv
// Shared definitions for the VME memory master: FSM state encoding and data constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vme_mem_master_pkg;

  localparam int DATA_W = 16;

  // Read data returned to the host when a transaction is aborted on timeout.
  localparam logic [DATA_W-1:0] TIMEOUT_RDATA = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STROBE = 2'd1,
    ST_WAIT   = 2'd2
  } state_e;

endpackage

// File: rtl/vme_mem_master.sv
// Single-outstanding host-to-VME memory master: strobe the slave once, wait for its done, ack the host.
// Latency: host_req cycle N -> strobe N+1 -> (registered slave done N+2) -> host_ack N+3; timeout ack at N+2+TIMEOUT.
// Backpressure: host_busy; a host_req while busy (including the ack cycle) is discarded and flagged on host_drop.
// Ports: Clk/Rst (async active-high); host_* request/response side; VME* slave side; timeout_count saturating abort tally.
module vme_mem_master
  import vme_mem_master_pkg::*;
#(
  parameter int ADDR_WIDTH = 2,
  parameter int TIMEOUT    = 15
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-2:0] host_addr,
  input  logic [DATA_W-1:0]     host_wdata,
  output logic                  host_busy,
  output logic                  host_ack,
  output logic                  host_err,
  output logic [DATA_W-1:0]     host_rdata,
  output logic                  host_drop,
  output logic [ADDR_WIDTH-1:1] VMEAddr,
  output logic [DATA_W-1:0]     VMEWrData,
  output logic                  VMERdMem,
  output logic                  VMEWrMem,
  input  logic [DATA_W-1:0]     VMERdData,
  input  logic                  VMERdDone,
  input  logic                  VMEWrDone,
  output logic [7:0]            timeout_count
);

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:1] addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic                  rd_mem_q, rd_mem_d;
  logic                  wr_mem_q, wr_mem_d;
  logic                  busy_q, busy_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  logic                  drop_q, drop_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [7:0]            tocnt_q, tocnt_d;

  logic accept;
  logic done_match;
  logic wait_expired;

  // busy_q is still high in the ack cycle, so a request there is dropped rather than accepted.
  assign accept       = (state_q == ST_IDLE) && host_req && !busy_q;
  // Only the done matching the latched direction counts; the other one is ignored.
  assign done_match   = we_q ? VMEWrDone : VMERdDone;
  assign wait_expired = (cnt_q == WAIT_LAST);

  // State register (all outputs are flops as well).
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q  <= ST_IDLE;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rd_mem_q <= 1'b0;
      wr_mem_q <= 1'b0;
      busy_q   <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      drop_q   <= 1'b0;
      rdata_q  <= '0;
      cnt_q    <= '0;
      tocnt_q  <= '0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rd_mem_q <= rd_mem_d;
      wr_mem_q <= wr_mem_d;
      busy_q   <= busy_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      drop_q   <= drop_d;
      rdata_q  <= rdata_d;
      cnt_q    <= cnt_d;
      tocnt_q  <= tocnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = ST_STROBE;
      ST_STROBE: state_d = ST_WAIT;
      ST_WAIT:   if (done_match || wait_expired) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output / datapath logic; every value here lands in a register.
  always_comb begin
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rd_mem_d = 1'b0;
    wr_mem_d = 1'b0;
    busy_d   = busy_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    drop_d   = host_req && busy_q;
    rdata_d  = rdata_q;
    cnt_d    = cnt_q;
    tocnt_d  = tocnt_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          we_d     = host_we;
          addr_d   = host_addr;
          wdata_d  = host_wdata;
          busy_d   = 1'b1;
          // Strobe is registered here so it coincides with the STROBE state.
          rd_mem_d = !host_we;
          wr_mem_d = host_we;
        end else begin
          busy_d = 1'b0;
        end
      end
      ST_STROBE: begin
        cnt_d = '0;
      end
      ST_WAIT: begin
        // Done takes priority over a coincident timeout.
        if (done_match) begin
          ack_d = 1'b1;
          if (!we_q) rdata_d = VMERdData;
        end else if (wait_expired) begin
          ack_d   = 1'b1;
          err_d   = 1'b1;
          rdata_d = TIMEOUT_RDATA;
          if (tocnt_q != 8'hFF) tocnt_d = tocnt_q + 8'd1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: ;
    endcase
  end

  assign host_busy     = busy_q;
  assign host_ack      = ack_q;
  assign host_err      = err_q;
  assign host_rdata    = rdata_q;
  assign host_drop     = drop_q;
  assign VMEAddr       = addr_q;
  assign VMEWrData     = wdata_q;
  assign VMERdMem      = rd_mem_q;
  assign VMEWrMem      = wr_mem_q;
  assign timeout_count = tocnt_q;

endmodule
